// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle for priority_scan_encoder: input vector channel and per-bit index output channel.
interface priority_scan_encoder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;
  logic             out_multi;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, out_multi
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, out_multi
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// Accepts a bit vector, then emits one beat per set bit (lowest- or highest-first) with
// per-vector none/multi flags; an all-zero vector yields a single index-0 beat.
module priority_scan_encoder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  priority_scan_encoder_if.slave io_bus
);
  localparam int unsigned      IDX_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_pending, w_pending_next;
  logic             r_none, w_none_next;
  logic             r_multi, w_multi_next;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_sel;
  logic             w_one_left;
  logic             w_last;
  logic             w_in_multi;

  // Later matches overwrite earlier ones, so the loop direction sets the priority.
  always_comb begin
    w_idx = '0;
    if (LSB_FIRST) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (r_pending[i]) w_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_pending[i]) w_idx = IDX_W'(i);
      end
    end
  end

  assign w_sel      = LSB_ONE << w_idx;
  assign w_one_left = (r_pending != '0) && ((r_pending & (r_pending - LSB_ONE)) == '0);
  assign w_last     = r_none | w_one_left;
  assign w_in_multi = (io_bus.in_data & (io_bus.in_data - LSB_ONE)) != '0;

  assign io_bus.in_ready  = (r_state == StIdle);
  assign io_bus.out_valid = (r_state == StEmit);
  assign io_bus.out_idx   = w_idx;
  assign io_bus.out_last  = w_last;
  assign io_bus.out_none  = r_none;
  assign io_bus.out_multi = r_multi;

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_none_next    = r_none;
    w_multi_next   = r_multi;
    unique case (r_state)
      StIdle: begin
        if (io_bus.in_valid) begin
          w_state_next   = StEmit;
          w_pending_next = io_bus.in_data;
          w_none_next    = (io_bus.in_data == '0);
          w_multi_next   = w_in_multi;
        end
      end
      StEmit: begin
        if (io_bus.out_ready) begin
          w_pending_next = r_pending & ~w_sel;
          if (w_last) begin
            w_state_next = StIdle;
            w_none_next  = 1'b0;
            w_multi_next = 1'b0;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_none    <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_none    <= w_none_next;
      r_multi   <= w_multi_next;
    end
  end
endmodule

// File: tb/tb_priority_scan_encoder.sv
// Drives LSB-first and MSB-first encoders with identical stimulus; a reference queue per DUT
// holds the expected beats and an ordered negedge monitor compares against it.
module tb_priority_scan_encoder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  priority_scan_encoder_if #(.WIDTH(8)) bus0 ();
  priority_scan_encoder_if #(.WIDTH(8)) bus1 ();

  priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus0)
  );

  priority_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus1)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       none;
    logic       multi;
  } beat_t;

  beat_t q[2][$];
  logic  rst_seen = 1'b0;

  task automatic chk(input string name, input int d, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0d exp=%0d t=%0t", name, d, got, exp, $time);
    end
  endtask

  // Reference: list the set bits, order them by scan direction, one beat each.
  task automatic push_vec(input int d, input logic [7:0] v);
    int    idxs[$];
    int    n;
    beat_t b;
    for (int i = 0; i < 8; i++) if (v[i]) idxs.push_back(i);
    n = idxs.size();
    if (n == 0) begin
      b = '{idx: 3'd0, last: 1'b1, none: 1'b1, multi: 1'b0};
      q[d].push_back(b);
    end else begin
      for (int k = 0; k < n; k++) begin
        b.idx   = 3'(d == 0 ? idxs[k] : idxs[n-1-k]);
        b.last  = (k == n - 1);
        b.none  = 1'b0;
        b.multi = (n >= 2);
        q[d].push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    logic       ov, ir, iv, ordy, lst, non, mul;
    logic [2:0] idx;
    logic [7:0] dat;
    logic       exp_busy;
    for (int d = 0; d < 2; d++) begin
      ov   = (d == 0) ? bus0.out_valid : bus1.out_valid;
      ir   = (d == 0) ? bus0.in_ready  : bus1.in_ready;
      iv   = (d == 0) ? bus0.in_valid  : bus1.in_valid;
      ordy = (d == 0) ? bus0.out_ready : bus1.out_ready;
      idx  = (d == 0) ? bus0.out_idx   : bus1.out_idx;
      lst  = (d == 0) ? bus0.out_last  : bus1.out_last;
      non  = (d == 0) ? bus0.out_none  : bus1.out_none;
      mul  = (d == 0) ? bus0.out_multi : bus1.out_multi;
      dat  = (d == 0) ? bus0.in_data   : bus1.in_data;
      exp_busy = (q[d].size() != 0);
      chk("out_valid", d, int'(ov), int'(exp_busy));
      chk("in_ready", d, int'(ir), int'(!exp_busy));
      if (rst_seen && !rst) begin
        chk("rst_idx", d, int'(idx), 0);
        chk("rst_last", d, int'(lst), 0);
        chk("rst_none", d, int'(non), 0);
        chk("rst_multi", d, int'(mul), 0);
      end
      if (ov && exp_busy) begin
        chk("idx", d, int'(idx), int'(q[d][0].idx));
        chk("last", d, int'(lst), int'(q[d][0].last));
        chk("none", d, int'(non), int'(q[d][0].none));
        chk("multi", d, int'(mul), int'(q[d][0].multi));
      end
      if (rst) begin
        q[d].delete();
      end else begin
        if (exp_busy && ordy) void'(q[d].pop_front());
        if (!exp_busy && iv) push_vec(d, dat);
      end
    end
    rst_seen = rst;
  end

  task automatic set_in(input logic v, input logic [7:0] dat);
    bus0.in_valid = v;
    bus1.in_valid = v;
    bus0.in_data  = dat;
    bus1.in_data  = dat;
  endtask

  task automatic set_ordy(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] v);
    int n = 0;
    set_in(1'b1, v);
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.in_ready && n < 100);
    if (!bus0.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=busy exp=ready t=%0t", $time);
    end
    @(posedge clk);
    #1;
    set_in(1'b0, 8'h00);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q[0].size() != 0 || q[1].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d,%0d exp=0,0 t=%0t", q[0].size(), q[1].size(), $time);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    int         mode;
    rst = 1'b1;
    set_in(1'b0, 8'h00);
    set_ordy(1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    send(8'b0010_0000);
    wait_idle();
    send(8'b1000_1010);
    wait_idle();
    send(8'b0000_0000);
    wait_idle();

    // Stall, with in_valid pulses that must be ignored while emitting.
    set_ordy(1'b0);
    send(8'b0000_0110);
    repeat (3) begin
      set_in(1'b1, 8'($urandom));
      @(posedge clk);
      #1;
    end
    set_in(1'b0, 8'h00);
    set_ordy(1'b1);
    wait_idle();

    send(8'b1111_1111);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'b0000_0001);
    wait_idle();

    for (int c = 0; c < 2000; c++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0) v = 8'h00;
      else if (mode == 1) v = 8'(1) << $urandom_range(0, 7);
      else v = 8'($urandom);
      set_in(1'($urandom_range(0, 1)), v);
      set_ordy($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    set_in(1'b0, 8'h00);
    set_ordy(1'b1);
    wait_idle();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
